// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - handshaked RV32 load/store controller in front of a word RAM (optional DMEM_MISALIGN_EN)
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 20,
    parameter int DEPTH      = 1 << (ADDR_WIDTH - 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int WW = ADDR_WIDTH - 2;

`ifdef DMEM_MISALIGN_EN
    localparam int LANES = 8;
    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI} state_t;
`else
    localparam int LANES = 4;
    typedef enum logic [1:0] {IDLE, ACC_LO} state_t;
`endif

    logic [31:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            f3_q, f3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
`ifdef DMEM_MISALIGN_EN
    logic [31:0]           lo_word_q, lo_word_d;
    logic [WW-1:0]         widx_nx;
    logic                  straddle;
`endif

    logic [1:0]           off;
    logic [WW-1:0]        widx;
    logic [3:0]           be_base;
    logic [LANES-1:0]     be_w;
    logic [8*LANES-1:0]   wd_w;
    logic [8*LANES-1:0]   rd_w;
    logic [31:0]          raw;
    logic [31:0]          load_ext;
    logic                 illegal;
    logic                 err;
    logic                 unused_addr_hi;

    // Bits above ADDR_WIDTH alias and are deliberately ignored.
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Decode the captured request: lanes, shifted store data, error and straddle flags.
    always_comb begin
        off  = addr_q[1:0];
        widx = addr_q[ADDR_WIDTH-1:2];
        case (f3_q[1:0])
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
        be_w = LANES'({4'b0000, be_base} << off);
        wd_w = (8*LANES)'({32'h0, wdata_q} << {off, 3'b000});
        if (we_q)
            illegal = (f3_q > 3'b010);
        else
            illegal = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111);
`ifdef DMEM_MISALIGN_EN
        widx_nx  = (widx == WW'(DEPTH - 1)) ? '0 : widx + 1'b1;
        straddle = ((f3_q[1:0] == 2'b01) && (off == 2'd3)) ||
                   ((f3_q[1:0] == 2'b10) && (off != 2'd0));
        err      = illegal;
        if (state_q == ACC_HI)
            rd_w = {mem[widx_nx], lo_word_q};
        else
            rd_w = {32'h0, mem[widx]};
`else
        err  = illegal ||
               ((f3_q[1:0] == 2'b01) && off[0]) ||
               ((f3_q[1:0] == 2'b10) && (off != 2'd0));
        rd_w = mem[widx];
`endif
        raw = 32'(rd_w >> {off, 3'b000});
        case (f3_q)
            3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_ext = {24'h0, raw[7:0]};
            3'b101:  load_ext = {16'h0, raw[15:0]};
            default: load_ext = raw;
        endcase
    end

    // Next-state and registered-response computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
`ifdef DMEM_MISALIGN_EN
        lo_word_d   = lo_word_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDR_WIDTH-1:0];
                    wdata_d = req_wdata;
                    state_d = ACC_LO;
                end
            end
            ACC_LO: begin
                if (err) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
`ifdef DMEM_MISALIGN_EN
                end else if (straddle) begin
                    lo_word_d = mem[widx];
                    state_d   = ACC_HI;
`endif
                end else begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : load_ext;
                end
            end
`ifdef DMEM_MISALIGN_EN
            ACC_HI: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = we_q ? 32'h0 : load_ext;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset drops any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_EN
            lo_word_q   <= 32'h0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_MISALIGN_EN
            lo_word_q   <= lo_word_d;
`endif
        end
    end

    // Byte-lane writes: low lanes on the ACC_LO exit edge, spill lanes on the ACC_HI exit edge.
    always_ff @(posedge clk) begin
        if (!rst && we_q && !err) begin
            if (state_q == ACC_LO) begin
                for (int i = 0; i < 4; i++)
                    if (be_w[i]) mem[widx][8*i +: 8] <= wd_w[8*i +: 8];
            end
`ifdef DMEM_MISALIGN_EN
            if (state_q == ACC_HI) begin
                for (int i = 0; i < 4; i++)
                    if (be_w[4+i]) mem[widx_nx][8*i +: 8] <= wd_w[32+8*i +: 8];
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int tests = 0;
    int fails = 0;

    dmem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; checks latency, single-cycle pulse, data, error flag and ready.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        int k;
        k = 0;
        @(negedge clk);
        chk({tag, " ready_before"}, {31'h0, req_ready}, 32'd1);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) k = i;
        end
        chk({tag, " latency"}, k, exp_lat);
        if (k != 0) begin
            chk({tag, " rdata"}, rsp_rdata, exp_d);
            chk({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp_e});
            chk({tag, " ready_with_rsp"}, {31'h0, req_ready}, 32'd1);
            @(negedge clk);
            chk({tag, " pulse_width"}, {31'h0, rsp_valid}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pulses;

        // reset state
        @(negedge clk);
        chk("rst rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst req_ready", {31'h0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst req_ready", {31'h0, req_ready}, 32'd1);

        // word store/load
        do_req("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        do_req("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        // byte store and sign/zero-extended loads
        do_req("sb_101", 1'b1, 3'b000, 32'h101, 32'h00000080, 32'h0, 1'b0, 2);
        do_req("lb_101", 1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        do_req("lbu_101", 1'b0, 3'b100, 32'h101, 32'h0, 32'h00000080, 1'b0, 2);
        do_req("lw_100b", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0, 2);

        // halfword store and loads in the upper half of another word
        do_req("sh_106", 1'b1, 3'b001, 32'h106, 32'hFFFFABCD, 32'h0, 1'b0, 2);
        do_req("lh_106", 1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFFABCD, 1'b0, 2);
        do_req("lhu_106", 1'b0, 3'b101, 32'h106, 32'h0, 32'h0000ABCD, 1'b0, 2);
        do_req("lbu_107", 1'b0, 3'b100, 32'h107, 32'h0, 32'h000000AB, 1'b0, 2);

        // illegal funct3 leaves memory untouched
        do_req("st_f3_011", 1'b1, 3'b011, 32'h100, 32'h12345678, 32'h0, 1'b1, 2);
        do_req("lw_after_ill", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0, 2);
        do_req("ld_f3_110", 1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 2);

        // upper address bits alias
        do_req("lw_alias", 1'b0, 3'b010, 32'h80100100, 32'h0, 32'hDEAD80EF, 1'b0, 2);

`ifdef DMEM_MISALIGN_EN
        do_req("sw_102_split", 1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 1'b0, 3);
        do_req("lw_102_split", 1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 1'b0, 3);
        do_req("lbu_100_kept", 1'b0, 3'b100, 32'h100, 32'h0, 32'h000000EF, 1'b0, 2);
        do_req("lbu_101_kept", 1'b0, 3'b100, 32'h101, 32'h0, 32'h00000080, 1'b0, 2);
        do_req("lh_101_inword", 1'b0, 3'b001, 32'h101, 32'h0, 32'h00004480, 1'b0, 2);
`else
        do_req("lh_103_mis", 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 1'b1, 2);
        do_req("sw_102_mis", 1'b1, 3'b010, 32'h102, 32'h11223344, 32'h0, 1'b1, 2);
        do_req("sh_101_mis", 1'b1, 3'b001, 32'h101, 32'h00005555, 32'h0, 1'b1, 2);
        do_req("lw_after_mis", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0, 2);
`endif

        // continuous req_valid: one accept every two cycles
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104; req_valid = 1'b1;
        acc = 0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready) acc++;
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b accepts", acc, 32'd5);
        chk("b2b responses", pulses, 32'd4);
        repeat (3) @(negedge clk);

        // reset mid-operation: no response afterwards
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst req_ready", {31'h0, req_ready}, 32'd0);
        chk("midrst rsp_valid", {31'h0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("midrst no_rsp", pulses, 32'd0);
        do_req("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD80EF, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
